iir_sos_tm_engine: RTL and testbench



---
 rtl/iir_sos_tm_engine.sv | 150 +++++++++++++++
 tb/tb_iir_sos_tm_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sos_tm_engine.sv
// Time-multiplexed cascade of NUM_SOS transposed-DF2 biquads. One shared section
// datapath evaluates one section per clock. Every section output is rounded and saturated.
module iir_sos_tm_engine #(
  parameter int DW      = 16,
  parameter int DF      = 12,
  parameter int CW      = 16,
  parameter int CF      = 14,
  parameter int NUM_SOS = 4,
  parameter int AW      = $clog2(6*NUM_SOS)
) (
  input  logic          CLK_en,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  output logic [DW-1:0] y_out,
  output logic          out_valid,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic          state_clr,
  input  logic          ovf_clr,
  output logic          overflow
);

  if (NUM_SOS < 1 || NUM_SOS > 16 || DF >= DW || CF >= CW) begin : g_param_check
    $error("iir_sos_tm_engine: unsupported parameter combination");
  end

  localparam int KW = (NUM_SOS > 1) ? $clog2(NUM_SOS) : 1;
  localparam int PW = DW + CW;
  localparam int SW = PW + 2;
  localparam logic signed [CW-1:0] ONE  = CW'(1 << CF);
  localparam logic signed [SW-1:0] HALF = SW'(1 << (CF-1));
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (DW-1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  localparam logic [KW-1:0]        LAST = KW'(NUM_SOS-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;
  logic [KW-1:0]        k;
  logic signed [DW-1:0] v;
  logic signed [CW-1:0] coef [NUM_SOS][6];
  logic signed [DW-1:0] s1 [NUM_SOS];
  logic signed [DW-1:0] s2 [NUM_SOS];

  logic signed [CW-1:0] g, b0, b1, b2, a1, a2;
  logic signed [PW-1:0] p_gv;
  logic signed [DW-1:0] xs, y, s1n, s2n;
  logic                 sat_xs, sat_y, sat_s1, sat_s2, any_sat;

  // Round half up from CF extra fractional bits, then clamp to the DW range.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [SW-1:0] acc,
                                                     output logic sat);
    logic signed [SW-1:0] r;
    r = (acc + HALF) >>> CF;
    sat = 1'b1;
    if (r > MAXV)      round_sat = MAXV[DW-1:0];
    else if (r < MINV) round_sat = MINV[DW-1:0];
    else begin
      sat = 1'b0;
      round_sat = r[DW-1:0];
    end
  endfunction

  always_comb begin
    g  = coef[k][0];
    b0 = coef[k][1];
    b1 = coef[k][2];
    b2 = coef[k][3];
    a1 = coef[k][4];
    a2 = coef[k][5];
    p_gv = PW'(v) * PW'(g);
    xs  = round_sat(SW'(p_gv), sat_xs);
    y   = round_sat(SW'(PW'(xs) * PW'(b0)) + (SW'(s1[k]) <<< CF), sat_y);
    s1n = round_sat(SW'(PW'(xs) * PW'(b1)) - SW'(PW'(y) * PW'(a1))
                    + (SW'(s2[k]) <<< CF), sat_s1);
    s2n = round_sat(SW'(PW'(xs) * PW'(b2)) - SW'(PW'(y) * PW'(a2)), sat_s2);
    any_sat = sat_xs | sat_y | sat_s1 | sat_s2;
  end

  always_ff @(posedge CLK_en) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (k == LAST) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Coefficient and state updates are only legal in IDLE so a running sample sees a stable set.
  always_ff @(posedge CLK_en) begin
    if (!RESET) begin
      k        <= '0;
      v        <= '0;
      y_out    <= '0;
      overflow <= 1'b0;
      for (int s = 0; s < NUM_SOS; s++) begin
        s1[s]      <= '0;
        s2[s]      <= '0;
        coef[s][0] <= ONE;
        coef[s][1] <= ONE;
        for (int i = 2; i < 6; i++) coef[s][i] <= '0;
      end
    end else begin
      if (state == RUN) begin
        v     <= y;
        k     <= k + 1'b1;
        s1[k] <= s1n;
        s2[k] <= s2n;
        if (k == LAST) y_out <= y;
      end
      if (state == IDLE) begin
        if (in_valid) begin
          v <= x_in;
          k <= '0;
        end
        if (state_clr) begin
          for (int s = 0; s < NUM_SOS; s++) begin
            s1[s] <= '0;
            s2[s] <= '0;
          end
        end
        if (coef_we) begin
          for (int s = 0; s < NUM_SOS; s++)
            for (int i = 0; i < 6; i++)
              if (coef_addr == AW'(s*6 + i)) coef[s][i] <= coef_data;
        end
      end
      if (state == RUN && any_sat) overflow <= 1'b1;
      else if (ovf_clr)            overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iir_sos_tm_engine.sv
// Randomised self-checking bench for iir_sos_tm_engine against a per-sample cascade model.
module tb_iir_sos_tm_engine;

  localparam int DW = 16;
  localparam int DF = 12;
  localparam int CW = 16;
  localparam int CF = 14;
  localparam int N  = 4;
  localparam int AW = $clog2(6*N);

  logic          CLK_en = 1'b0;
  logic          RESET = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x_in = '0;
  logic [DW-1:0] y_out;
  logic          out_valid;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          state_clr = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          overflow;

  iir_sos_tm_engine #(.DW(DW), .DF(DF), .CW(CW), .CF(CF), .NUM_SOS(N)) dut (
    .CLK_en(CLK_en), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_out(y_out), .out_valid(out_valid), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .state_clr(state_clr),
    .ovf_clr(ovf_clr), .overflow(overflow)
  );

  always #5 CLK_en = ~CLK_en;

  int checks = 0;
  int errors = 0;

  longint m_coef [N][6];
  longint m_s1 [N];
  longint m_s2 [N];
  bit     m_ovf;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int s = 0; s < N; s++) begin
      m_coef[s][0] = 1 << CF;
      m_coef[s][1] = 1 << CF;
      for (int i = 2; i < 6; i++) m_coef[s][i] = 0;
      m_s1[s] = 0;
      m_s2[s] = 0;
    end
    m_ovf = 0;
  endfunction

  // Round half up to the sample grid, then clamp; clamping raises the model flag.
  function automatic longint modelRound(input longint acc);
    longint r;
    longint maxv;
    longint minv;
    maxv = (longint'(1) << (DW-1)) - 1;
    minv = -(longint'(1) << (DW-1));
    r = (acc + (longint'(1) << (CF-1))) >>> CF;
    if (r > maxv) begin m_ovf = 1; return maxv; end
    if (r < minv) begin m_ovf = 1; return minv; end
    return r;
  endfunction

  function automatic longint modelSample(input logic [DW-1:0] x);
    longint v;
    longint xs;
    longint y;
    longint n1;
    longint n2;
    longint scale;
    scale = longint'(1) << CF;
    v = longint'($signed(x));
    for (int s = 0; s < N; s++) begin
      xs = modelRound(m_coef[s][0] * v);
      y  = modelRound(m_coef[s][1] * xs + m_s1[s] * scale);
      n1 = modelRound(m_coef[s][2] * xs - m_coef[s][4] * y + m_s2[s] * scale);
      n2 = modelRound(m_coef[s][3] * xs - m_coef[s][5] * y);
      m_s1[s] = n1;
      m_s2[s] = n2;
      v = y;
    end
    return v;
  endfunction

  task automatic writeCoef(input int addr, input int data);
    logic signed [CW-1:0] d;
    d = CW'(data);
    @(negedge CLK_en);
    coef_we = 1'b1;
    coef_addr = AW'(addr);
    coef_data = d;
    @(negedge CLK_en);
    coef_we = 1'b0;
    if (addr < 6*N) m_coef[addr/6][addr%6] = longint'(d);
  endtask

  task automatic pulseStateClr();
    @(negedge CLK_en);
    state_clr = 1'b1;
    @(negedge CLK_en);
    state_clr = 1'b0;
    for (int s = 0; s < N; s++) begin
      m_s1[s] = 0;
      m_s2[s] = 0;
    end
  endtask

  task automatic pulseOvfClr();
    @(negedge CLK_en);
    ovf_clr = 1'b1;
    @(negedge CLK_en);
    ovf_clr = 1'b0;
    m_ovf = 0;
  endtask

  task automatic startSample(input logic [DW-1:0] x, output longint expected);
    int w;
    w = 0;
    @(negedge CLK_en);
    while (!in_ready && w < 20) begin
      @(negedge CLK_en);
      w++;
    end
    if (!in_ready) checkOutput("ready_timeout", 0, 1);
    in_valid = 1'b1;
    x_in = x;
    @(posedge CLK_en);
    expected = modelSample(x);
  endtask

  // Optionally keeps in_valid high with a changing x_in, or pokes a coefficient mid-run.
  task automatic finishSample(input longint expected, input bit hold, input bit poke,
                              input int poke_addr, input int poke_data, input string tag);
    int  cyc;
    int  low;
    bit  seen;
    cyc = 0;
    low = 0;
    seen = 0;
    for (int c = 0; c <= 3*N; c++) begin
      @(negedge CLK_en);
      if (!in_ready) low++;
      if (out_valid) begin
        seen = 1;
        cyc = c;
        break;
      end
      if (hold) x_in = DW'($urandom);
      else      in_valid = 1'b0;
      coef_we = poke && (c == 0);
      coef_addr = AW'(poke_addr);
      coef_data = CW'(poke_data);
    end
    in_valid = 1'b0;
    coef_we = 1'b0;
    checkOutput({tag, "_seen"}, longint'(seen), 1);
    if (seen) begin
      checkOutput({tag, "_latency"}, cyc, N);
      checkOutput({tag, "_rdylow"}, low, N+1);
      checkOutput({tag, "_y"}, longint'($signed(y_out)), expected);
      checkOutput({tag, "_ovf"}, longint'(overflow), longint'(m_ovf));
      @(negedge CLK_en);
      checkOutput({tag, "_pulse"}, longint'(out_valid), 0);
      checkOutput({tag, "_rdy"}, longint'(in_ready), 1);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] x, input string tag);
    longint e;
    startSample(x, e);
    finishSample(e, 1'b0, 1'b0, 0, 0, tag);
  endtask

  initial begin
    longint e;
    int     ov;
    modelReset();
    repeat (3) @(negedge CLK_en);
    checkOutput("rst_y", longint'(y_out), 0);
    checkOutput("rst_valid", longint'(out_valid), 0);
    checkOutput("rst_ovf", longint'(overflow), 0);
    checkOutput("rst_rdy", longint'(in_ready), 1);
    RESET = 1'b1;

    applyStimulus(16'h0100, "pass");
    checkOutput("pass_lit", longint'($signed(y_out)), 256);

    writeCoef(1, 8192);
    writeCoef(4, -8192);
    applyStimulus(16'd4096, "imp0");
    checkOutput("imp0_lit", longint'($signed(y_out)), 2048);
    applyStimulus(16'd0, "imp1");
    checkOutput("imp1_lit", longint'($signed(y_out)), 1024);
    applyStimulus(16'd0, "imp2");
    checkOutput("imp2_lit", longint'($signed(y_out)), 512);

    pulseStateClr();
    applyStimulus(16'd0, "clr");
    checkOutput("clr_lit", longint'($signed(y_out)), 0);

    writeCoef(1, 32767);
    writeCoef(4, 0);
    applyStimulus(16'h7FFF, "sat");
    checkOutput("sat_lit", longint'(y_out), 32767);
    checkOutput("sat_ovf_lit", longint'(overflow), 1);
    applyStimulus(16'h0100, "sat_clean");
    checkOutput("sat_sticky", longint'(overflow), 1);
    pulseOvfClr();
    checkOutput("ovf_clr", longint'(overflow), 0);

    startSample(16'h0100, e);
    finishSample(e, 1'b0, 1'b1, 1, 8192, "runwr");
    checkOutput("runwr_lit", longint'($signed(y_out)), 512);
    writeCoef(1, 8192);
    applyStimulus(16'h0100, "idlewr");
    checkOutput("idlewr_lit", longint'($signed(y_out)), 128);
    writeCoef(6*N, 1000);
    applyStimulus(16'h0100, "oorwr");

    startSample(16'h0200, e);
    finishSample(e, 1'b1, 1'b0, 0, 0, "hold");

    for (int a = 0; a < 6*N; a++) begin
      if (a % 6 < 2) writeCoef(a, int'($urandom_range(8192, 24576)));
      else           writeCoef(a, int'($urandom_range(0, 16383)) - 8192);
    end
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 4) pulseStateClr();
      if (i % 7 == 3) pulseOvfClr();
      if (i % 3 == 0) applyStimulus(DW'($urandom), "rnd");
      else            applyStimulus(DW'(int'($urandom_range(0, 16383)) - 8192), "rnd");
    end

    startSample(16'h1234, e);
    @(negedge CLK_en);
    in_valid = 1'b0;
    @(negedge CLK_en);
    RESET = 1'b0;
    @(negedge CLK_en);
    checkOutput("midrst_valid", longint'(out_valid), 0);
    checkOutput("midrst_y", longint'(y_out), 0);
    checkOutput("midrst_rdy", longint'(in_ready), 1);
    checkOutput("midrst_ovf", longint'(overflow), 0);
    RESET = 1'b1;
    modelReset();
    ov = 0;
    for (int c = 0; c < 2*N; c++) begin
      @(negedge CLK_en);
      if (out_valid) ov++;
    end
    checkOutput("midrst_novalid", ov, 0);
    applyStimulus(16'hF123, "postrst");
    checkOutput("postrst_lit", longint'(y_out), 16'hF123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
